// File: rtl/crack_result_uart.sv
// Reports the RC4 key-search outcome over an 8N1 UART: "KEY xxxxxx <msg>\r\n" or "NO KEY\r\n".
// Message bytes come from the decrypted RAM's second port (2-cycle read latency).
`timescale 1ns/1ps
module crack_result_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        good,
  input  logic        bad,
  input  logic [23:0] secret_key,
  output logic [4:0]  address_r,
  input  logic [7:0]  read_r,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [5:0] MSG_FIRST = 6'd11;
  localparam logic [5:0] MSG_LAST  = 6'(10 + MSG_LEN);
  localparam logic [5:0] CR_IDX    = 6'(11 + MSG_LEN);
  localparam logic [5:0] GOOD_LAST = 6'(12 + MSG_LEN);
  localparam logic [5:0] BAD_LAST  = 6'd7;

  typedef enum logic [3:0] {
    IDLE, SEL, RAM_ADDR, RAM_WAIT1, RAM_WAIT2, LOAD,
    TX_START, TX_DATA, TX_STOP, NEXT, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            arm_q, arm_d;
  logic            is_good_q, is_good_d;
  logic [23:0]     key_q, key_d;
  logic [5:0]      index_q, index_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [4:0]      addr_q, addr_d;

  logic            start_frame;
  logic            in_msg;
  logic            baud_wrap;
  logic            last_byte;
  logic [7:0]      const_char;
  logic [7:0]      ram_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  assign start_frame = arm_q && (good || bad);
  assign in_msg      = is_good_q && (index_q >= MSG_FIRST) && (index_q <= MSG_LAST);
  assign baud_wrap   = (baud_q == BAUD_MAX);
  assign last_byte   = (index_q == (is_good_q ? GOOD_LAST : BAD_LAST));
  assign ram_char    = ((read_r >= 8'h20) && (read_r <= 8'h7E)) ? read_r : 8'h2E;

  always_comb begin
    const_char = 8'h20;
    if (is_good_q) begin
      case (index_q)
        6'd0:    const_char = 8'h4B;
        6'd1:    const_char = 8'h45;
        6'd2:    const_char = 8'h59;
        6'd4:    const_char = hex_char(key_q[23:20]);
        6'd5:    const_char = hex_char(key_q[19:16]);
        6'd6:    const_char = hex_char(key_q[15:12]);
        6'd7:    const_char = hex_char(key_q[11:8]);
        6'd8:    const_char = hex_char(key_q[7:4]);
        6'd9:    const_char = hex_char(key_q[3:0]);
        default: begin
          if (index_q == CR_IDX)
            const_char = 8'h0D;
          else if (index_q == GOOD_LAST)
            const_char = 8'h0A;
        end
      endcase
    end else begin
      case (index_q)
        6'd0:    const_char = 8'h4E;
        6'd1:    const_char = 8'h4F;
        6'd3:    const_char = 8'h4B;
        6'd4:    const_char = 8'h45;
        6'd5:    const_char = 8'h59;
        6'd6:    const_char = 8'h0D;
        6'd7:    const_char = 8'h0A;
        default: const_char = 8'h20;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      arm_q     <= 1'b1;
      is_good_q <= 1'b0;
      key_q     <= '0;
      index_q   <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      is_good_q <= is_good_d;
      key_q     <= key_d;
      index_q   <= index_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_frame) state_d = SEL;
      SEL:       state_d = in_msg ? RAM_ADDR : LOAD;
      RAM_ADDR:  state_d = RAM_WAIT1;
      RAM_WAIT1: state_d = RAM_WAIT2;
      RAM_WAIT2: state_d = LOAD;
      LOAD:      state_d = TX_START;
      TX_START:  if (baud_wrap) state_d = TX_DATA;
      TX_DATA:   if (baud_wrap && (bit_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:   if (baud_wrap) state_d = NEXT;
      NEXT:      state_d = last_byte ? DONE : SEL;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Arm re-enables only once both flags are seen low in IDLE: one frame per flag assertion.
  always_comb begin
    arm_d     = arm_q;
    is_good_d = is_good_q;
    key_d     = key_q;
    index_d   = index_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        if (start_frame) begin
          arm_d     = 1'b0;
          is_good_d = good;
          key_d     = secret_key;
          index_d   = '0;
        end else if (!good && !bad) begin
          arm_d = 1'b1;
        end
      end
      SEL: if (in_msg) addr_d = 5'(index_q - MSG_FIRST);
      LOAD: begin
        shift_d = in_msg ? ram_char : const_char;
        baud_d  = '0;
        bit_d   = '0;
      end
      TX_START, TX_STOP: baud_d = baud_wrap ? '0 : baud_q + BW'(1);
      TX_DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + BW'(1);
        if (baud_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      NEXT: if (!last_byte) index_d = index_q + 6'd1;
      default: ;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (state_q == TX_START)
      tx = 1'b0;
    else if (state_q == TX_DATA)
      tx = shift_q[0];
    busy      = (state_q != IDLE) && (state_q != DONE);
    done      = (state_q == DONE);
    address_r = addr_q;
  end

endmodule

// File: tb/tb_crack_result_uart.sv
// Self-checking bench: decodes the UART line into bytes and compares them against a reference frame
// built from the report format (table of fixed vectors, hand sequences, randomized frames).
`timescale 1ns/1ps
module tb_crack_result_uart;

  localparam int CPB      = 4;
  localparam int MSG      = 32;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int BUDGET   = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        good;
  logic        bad;
  logic [23:0] secret_key;
  logic [4:0]  address_r;
  logic [7:0]  read_r;
  logic        tx;
  logic        busy;
  logic        done;

  crack_result_uart #(.CLKS_PER_BIT(CPB), .MSG_LEN(MSG)) dut (
    .clk(clk), .reset(reset), .good(good), .bad(bad), .secret_key(secret_key),
    .address_r(address_r), .read_r(read_r), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [MSG];
  always @(posedge clk) read_r <= ram[address_r];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q [$];
  int         start_q [$];
  logic [7:0] exp_q [$];
  int         exp_gap [$];
  int         done_cnt = 0;
  int         busy_seen = 0;
  int         tim_err = 0;

  typedef struct {
    bit          g;
    bit          b;
    logic [23:0] key;
    bit          flip;
    int          mode;
    string       text;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver: every cycle of every bit must hold the bit's value (exact baud timing).
  logic       samples [BYTE_CYC];
  logic [7:0] mon_byte;
  int         mon_sc;
  bit         mon_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_seen++;
      if (reset === 1'b0 && tx === 1'b0) begin
        mon_sc = cyc;
        mon_abort = 1'b0;
        samples[0] = tx;
        for (int i = 1; i < BYTE_CYC; i++) begin
          @(negedge clk);
          if (done === 1'b1) done_cnt++;
          if (busy === 1'b1) busy_seen++;
          if (reset !== 1'b0) begin
            mon_abort = 1'b1;
            break;
          end
          samples[i] = tx;
        end
        if (!mon_abort) begin
          for (int b = 0; b < 10; b++)
            for (int s = 0; s < CPB; s++)
              if (samples[b*CPB+s] !== samples[b*CPB]) tim_err++;
          if (samples[0] !== 1'b0) tim_err++;
          if (samples[9*CPB] !== 1'b1) tim_err++;
          for (int b = 0; b < 8; b++) mon_byte[b] = samples[(b+1)*CPB];
          rx_q.push_back(mon_byte);
          start_q.push_back(mon_sc);
        end
      end
    end
  end

  function automatic void set_gaps(input bit g);
    exp_gap.delete();
    for (int j = 0; j < exp_q.size(); j++)
      exp_gap.push_back((g && j >= 11 && j < 11 + MSG) ? 6 : 3);
  endfunction

  function automatic void build_expected(input bit g, input logic [23:0] k);
    string hexd = "0123456789ABCDEF";
    string hdr;
    int    nib;
    exp_q.delete();
    if (g) begin
      hdr = "KEY ";
      for (int i = 0; i < hdr.len(); i++) exp_q.push_back(hdr[i]);
      for (int i = 0; i < 6; i++) begin
        nib = int'((k >> (20 - 4*i)) & 24'hF);
        exp_q.push_back(hexd[nib]);
      end
      exp_q.push_back(8'h20);
      for (int a = 0; a < MSG; a++)
        exp_q.push_back((ram[a] >= 8'h20 && ram[a] <= 8'h7E) ? ram[a] : 8'h2E);
    end else begin
      hdr = "NO KEY";
      for (int i = 0; i < hdr.len(); i++) exp_q.push_back(hdr[i]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    set_gaps(g);
  endfunction

  function automatic void expected_from_text(input string t, input bit g);
    exp_q.delete();
    for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    set_gaps(g);
  endfunction

  task automatic load_ram(input int mode);
    string p = "the quick brown fox jumps over t";
    for (int a = 0; a < MSG; a++) ram[a] = p[a];
    if (mode == 1) begin
      ram[5] = 8'h07;
      ram[6] = 8'h80;
    end else if (mode == 2) begin
      ram[0] = 8'h1F;
      ram[1] = 8'h20;
      ram[2] = 8'h7E;
      ram[3] = 8'h7F;
    end
  endtask

  task automatic clear_capture();
    rx_q.delete();
    start_q.delete();
    done_cnt = 0;
    tim_err = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, " done_timeout"}, 32'(done_cnt == 0), 32'd0);
  endtask

  task automatic compare_frame(input string name);
    int n;
    int gap_err = 0;
    check({name, " byte_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int j = 0; j < n; j++)
      check($sformatf("%s byte%0d", name, j), rx_q[j], exp_q[j]);
    for (int j = 1; j < n; j++)
      if (start_q[j] - start_q[j-1] - BYTE_CYC != exp_gap[j]) gap_err++;
    check({name, " gap_errors"}, gap_err, 0);
    check({name, " bit_timing_errors"}, tim_err, 0);
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " busy_after"}, busy, 1'b0);
  endtask

  // Expected frame must already be in exp_q / exp_gap.
  task automatic run_frame(input bit g, input bit b, input logic [23:0] k, input bit flip,
                           input bit hold, input string name);
    clear_capture();
    @(negedge clk);
    good = g;
    bad = b;
    secret_key = k;
    check({name, " busy_before_start"}, busy, 1'b0);
    @(negedge clk);
    check({name, " busy_rise"}, busy, 1'b1);
    if (flip) secret_key = 24'hFFFFFF;
    wait_done(name);
    repeat (3) @(negedge clk);
    compare_frame(name);
    if (!hold) begin
      good = 1'b0;
      bad = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic applyStimulus();
    bit          g, b, fl;
    logic [23:0] k;
    int          n;

    tbl[0] = '{1'b1, 1'b0, 24'h2A0F3C, 1'b0, 0, "KEY 2A0F3C the quick brown fox jumps over t"};
    tbl[1] = '{1'b0, 1'b1, 24'h123456, 1'b0, 0, "NO KEY"};
    tbl[2] = '{1'b1, 1'b1, 24'h000001, 1'b0, 0, "KEY 000001 the quick brown fox jumps over t"};
    tbl[3] = '{1'b1, 1'b0, 24'h00BEEF, 1'b0, 1, "KEY 00BEEF the q..ck brown fox jumps over t"};
    tbl[4] = '{1'b1, 1'b0, 24'h5A5A5A, 1'b1, 0, "KEY 5A5A5A the quick brown fox jumps over t"};
    tbl[5] = '{1'b1, 1'b0, 24'hDCBA98, 1'b0, 2, "KEY DCBA98 . ~.quick brown fox jumps over t"};

    reset = 1'b1;
    good = 1'b0;
    bad = 1'b0;
    secret_key = '0;
    load_ram(0);
    repeat (2) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset address_r", address_r, 5'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle tx", tx, 1'b1);

    for (int i = 0; i < 6; i++) begin
      load_ram(tbl[i].mode);
      expected_from_text(tbl[i].text, tbl[i].g);
      run_frame(tbl[i].g, tbl[i].b, tbl[i].key, tbl[i].flip, 1'b0, $sformatf("vec%0d", i));
    end

    // Flag held high after its frame must not start another one.
    build_expected(1'b0, 24'h0);
    run_frame(1'b0, 1'b1, 24'h0, 1'b0, 1'b1, "bad_hold_first");
    busy_seen = 0;
    clear_capture();
    repeat (3 * 8 * 50) @(negedge clk);
    check("bad_hold no_busy", busy_seen, 0);
    check("bad_hold no_bytes", rx_q.size(), 0);
    bad = 1'b0;
    @(negedge clk);
    run_frame(1'b0, 1'b1, 24'h0, 1'b0, 1'b0, "bad_rearm");

    // Reset during data bit 3 of byte 12, then a full restart with good still high.
    load_ram(0);
    clear_capture();
    @(negedge clk);
    good = 1'b1;
    secret_key = 24'h3C5A96;
    n = 0;
    while (rx_q.size() < 12 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid reach_byte12", 32'(rx_q.size() >= 12), 32'd1);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid byte12_start", tx, 1'b0);
    repeat (4 * CPB + 1) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid tx", tx, 1'b1);
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid done", done, 1'b0);
    check("rst_mid address_r", address_r, 5'd0);
    repeat (2) @(negedge clk);
    clear_capture();
    build_expected(1'b1, 24'h3C5A96);
    reset = 1'b0;
    wait_done("rst_restart");
    repeat (3) @(negedge clk);
    compare_frame("rst_restart");
    good = 1'b0;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      k = 24'($urandom);
      n = int'($urandom_range(0, 2));
      g = (n != 1);
      b = (n != 0);
      fl = 1'($urandom_range(0, 1));
      for (int a = 0; a < MSG; a++) ram[a] = 8'($urandom_range(0, 255));
      build_expected(g, k);
      run_frame(g, b, k, fl, 1'b0, $sformatf("rand%0d", r));
    end
  endtask

  task automatic checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule
